// File: rtl/alu_share_sched_if.sv
// Requester/ALU bus for alu_share_sched: two requester lanes in, one shared ALU port out.
// The slave modport is the scheduler; the master modport is the requesters plus the ALU.
interface alu_share_sched_if #(
    parameter int DATA_W = 4,
    parameter int FUNC_W = 2
);
    logic [1:0]          req;
    logic [2*DATA_W-1:0] op_a;
    logic [2*DATA_W-1:0] op_b;
    logic [2*FUNC_W-1:0] op_func;
    logic [1:0]          gnt;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [FUNC_W-1:0]   alu_func;
    logic [2*DATA_W-1:0] alu_result;
    logic [1:0]          rsp_valid;
    logic [2*DATA_W-1:0] rsp_data;
    logic                busy;

    modport slave (
        input  req, op_a, op_b, op_func, alu_result,
        output gnt, alu_a, alu_b, alu_func, rsp_valid, rsp_data, busy
    );

    modport master (
        output req, op_a, op_b, op_func, alu_result,
        input  gnt, alu_a, alu_b, alu_func, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one fixed-latency ALU between two requesters.
// Optional per-requester completed-operation counters: define ALU_SHARE_SCHED_OPCNT_EN.
module alu_share_sched #(
    parameter int DATA_W  = 4,
    parameter int FUNC_W  = 2,
    parameter int ALU_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset_b,
    alu_share_sched_if.slave  sched_bus
`ifdef ALU_SHARE_SCHED_OPCNT_EN
    ,
    output logic [15:0]       op_count
`endif
);
    localparam int CNT_W = 3;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;
    logic                r_owner;
    logic [1:0]          r_gnt;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [FUNC_W-1:0]   r_alu_func;
    logic [2*DATA_W-1:0] r_rsp_data;
    logic                r_busy;

    logic                w_win;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [FUNC_W-1:0]   w_func;
    logic                w_cap;

    // On a tie the requester that was not served last wins; otherwise the sole requester.
    assign w_win  = (sched_bus.req == 2'b11) ? ~r_last : sched_bus.req[1];
    assign w_a    = w_win ? sched_bus.op_a[DATA_W +: DATA_W]    : sched_bus.op_a[0 +: DATA_W];
    assign w_b    = w_win ? sched_bus.op_b[DATA_W +: DATA_W]    : sched_bus.op_b[0 +: DATA_W];
    assign w_func = w_win ? sched_bus.op_func[FUNC_W +: FUNC_W] : sched_bus.op_func[0 +: FUNC_W];
    assign w_cap  = (r_state == EXEC) && (r_cnt == CNT_W'(ALU_LAT));

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_func  <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|sched_bus.req) begin
                        r_alu_a    <= w_a;
                        r_alu_b    <= w_b;
                        r_alu_func <= w_func;
                        r_gnt      <= w_win ? 2'b10 : 2'b01;
                        r_owner    <= w_win;
                        r_last     <= w_win;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Requests are not looked at here: an operation runs to completion.
                    if (w_cap) begin
                        r_rsp_data  <= sched_bus.alu_result;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_SCHED_OPCNT_EN
    logic [7:0] r_opcnt [2];

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_opcnt[0] <= '0;
            r_opcnt[1] <= '0;
        end else if (w_cap) begin
            r_opcnt[r_owner] <= r_opcnt[r_owner] + 8'd1;
        end
    end

    assign op_count = {r_opcnt[1], r_opcnt[0]};
`endif

    assign sched_bus.gnt       = r_gnt;
    assign sched_bus.rsp_valid = r_rsp_valid;
    assign sched_bus.alu_a     = r_alu_a;
    assign sched_bus.alu_b     = r_alu_b;
    assign sched_bus.alu_func  = r_alu_func;
    assign sched_bus.rsp_data  = r_rsp_data;
    assign sched_bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: ALU_LAT=1 instance against a timeline reference model,
// plus ALU_LAT=0 and ALU_LAT=7 instances for grant spacing.
module tb_alu_share_sched;
    localparam int DW   = 4;
    localparam int FW   = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_sched_if #(.DATA_W(DW), .FUNC_W(FW)) bus1 ();
    alu_share_sched_if #(.DATA_W(DW), .FUNC_W(FW)) bus0 ();
    alu_share_sched_if #(.DATA_W(DW), .FUNC_W(FW)) bus7 ();

`ifdef ALU_SHARE_SCHED_OPCNT_EN
    logic [15:0] opc1, opc0, opc7;
`endif

    alu_share_sched #(.DATA_W(DW), .FUNC_W(FW), .ALU_LAT(LAT1)) u_dut1 (
        .Clock(clk), .Reset_b(rst_n), .sched_bus(bus1)
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        , .op_count(opc1)
`endif
    );
    alu_share_sched #(.DATA_W(DW), .FUNC_W(FW), .ALU_LAT(0)) u_dut0 (
        .Clock(clk), .Reset_b(rst_n), .sched_bus(bus0)
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        , .op_count(opc0)
`endif
    );
    alu_share_sched #(.DATA_W(DW), .FUNC_W(FW), .ALU_LAT(7)) u_dut7 (
        .Clock(clk), .Reset_b(rst_n), .sched_bus(bus7)
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        , .op_count(opc7)
`endif
    );

    // Reference ALU: add, OR-reduce, AND-reduce, concatenate.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
        case (f)
            2'd0:    return {4'd0, a} + {4'd0, b};
            2'd1:    return {7'd0, |{a, b}};
            2'd2:    return {7'd0, &{a, b}};
            default: return {a, b};
        endcase
    endfunction

    // ALUs with the matching latencies, modelled as result pipelines.
    logic [7:0] alu1_q;
    logic [7:0] alu7_q [7];
    always_ff @(posedge clk) begin
        alu1_q    <= alu_ref(bus1.alu_a, bus1.alu_b, bus1.alu_func);
        alu7_q[0] <= alu_ref(bus7.alu_a, bus7.alu_b, bus7.alu_func);
        for (int s = 1; s < 7; s++) alu7_q[s] <= alu7_q[s-1];
    end
    assign bus1.alu_result = alu1_q;
    assign bus0.alu_result = alu_ref(bus0.alu_a, bus0.alu_b, bus0.alu_func);
    assign bus7.alu_result = alu7_q[6];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model of the ALU_LAT=1 instance: an operation granted at edge t
    // occupies the ALU until its result is captured at edge t+LAT+1.
    int         cyc;
    bit         m_idle;
    bit         m_last;
    bit         m_owner;
    int         m_cap;
    logic [7:0] m_res;
    logic [7:0] m_data;
    logic [9:0] m_alu;
    logic [1:0] m_gnt;
    int         m_cnt [2];

    task automatic model_reset();
        m_idle = 1'b1; m_last = 1'b1; m_owner = 1'b0; m_cap = 0;
        m_res = '0; m_data = '0; m_alu = '0; m_gnt = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic tick();
        logic [1:0] eg, ev;
        int wi;
        eg = '0; ev = '0;
        if (!m_idle && cyc == m_cap) begin
            ev = 2'b01 << m_owner;
            m_data = m_res;
            m_idle = 1'b1;
            m_cnt[m_owner]++;
        end else if (m_idle && bus1.req != 2'b00) begin
            wi = (bus1.req == 2'b11) ? int'(!m_last) : int'(bus1.req[1]);
            eg = 2'b01 << wi;
            m_owner = wi[0];
            m_last  = wi[0];
            m_alu = {bus1.op_a[wi*4 +: 4], bus1.op_b[wi*4 +: 4], bus1.op_func[wi*2 +: 2]};
            m_res = alu_ref(m_alu[9:6], m_alu[5:2], m_alu[1:0]);
            m_cap = cyc + LAT1 + 1;
            m_idle = 1'b0;
        end
        m_gnt = eg;
        @(posedge clk); #1;
        cyc++;
        chk("ctrl_gnt_rv_busy", {bus1.gnt, bus1.rsp_valid, bus1.busy}, {eg, ev, !m_idle});
        chk("rsp_data", bus1.rsp_data, m_data);
        chk("alu_inputs", {bus1.alu_a, bus1.alu_b, bus1.alu_func}, m_alu);
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
        bus1.op_a[i*4 +: 4]    = a;
        bus1.op_b[i*4 +: 4]    = b;
        bus1.op_func[i*2 +: 2] = f;
    endtask

    task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] f,
                          input logic [7:0] exp_d, input string tag);
        bit got;
        int nbusy;
        set_ops(i, a, b, f);
        bus1.req[i] = 1'b1;
        tick();
        bus1.req[i] = 1'b0;
        nbusy = int'(bus1.busy);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (bus1.rsp_valid == (2'b01 << i)) got = 1'b1;
            else nbusy += int'(bus1.busy);
        end
        chk({tag, "_rsp_seen"}, got, 1);
        chk({tag, "_rsp_data"}, bus1.rsp_data, exp_d);
        chk({tag, "_busy_cycles"}, nbusy, LAT1 + 1);
    endtask

    initial begin
        int nb, g, r0, r1, n0, n7, last0, last7, n_ops0;
        logic [1:0] exp_g;
        rst_n = 1'b0;
        bus1.req = '0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_func = '0;
        bus0.req = '0; bus0.op_a = '0; bus0.op_b = '0; bus0.op_func = '0;
        bus7.req = '0; bus7.op_a = '0; bus7.op_b = '0; bus7.op_func = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus1.gnt, bus1.rsp_valid, bus1.busy, bus1.rsp_data}, 0);
        chk("reset_alu_inputs", {bus1.alu_a, bus1.alu_b, bus1.alu_func}, 0);
        rst_n = 1'b1;

        run_op(0, 4'h3, 4'h5, 2'd0, 8'h08, "add_r0");
        run_op(1, 4'hA, 4'h5, 2'd3, 8'hA5, "concat_r1");
        run_op(1, 4'h0, 4'h1, 2'd1, 8'h01, "orred_r1");
        run_op(1, 4'hF, 4'h7, 2'd2, 8'h00, "andred_r1");

        // Operands changed right after the grant must not reach the result.
        set_ops(0, 4'h3, 4'h5, 2'd0);
        bus1.req[0] = 1'b1;
        tick();
        bus1.req[0] = 1'b0;
        set_ops(0, 4'hF, 4'hF, 2'd3);
        tick();
        tick();
        chk("sampled_at_grant", {bus1.rsp_valid, bus1.rsp_data}, {2'b01, 8'h08});

        // Requester 1 withdraws while requester 0 is being served.
        set_ops(0, 4'h1, 4'h2, 2'd0);
        bus1.req[0] = 1'b1;
        tick();
        bus1.req = 2'b10;
        set_ops(1, 4'h9, 4'h9, 2'd3);
        tick();
        bus1.req = 2'b00;
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            nb += int'(bus1.gnt[1]) + int'(bus1.rsp_valid[1]);
        end
        chk("withdraw_no_r1_activity", nb, 0);

        // Asynchronous reset in the middle of an operation.
        set_ops(1, 4'h6, 4'h6, 2'd0);
        bus1.req = 2'b10;
        tick();
        bus1.req = 2'b00;
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bus1.gnt, bus1.rsp_valid, bus1.busy, bus1.rsp_data}, 0);
        chk("async_reset_alu", {bus1.alu_a, bus1.alu_b, bus1.alu_func}, 0);
        model_reset();
        @(posedge clk); #1;
        cyc++;
        chk("reset_held_no_rsp", {bus1.rsp_valid, bus1.busy}, 0);
        #3 rst_n = 1'b1;

        // Fairness from reset: both requesting continuously for six grants.
        bus1.req = 2'b11;
        set_ops(0, 4'h2, 4'h3, 2'd0);
        set_ops(1, 4'hC, 4'h4, 2'd3);
        g = 0; r0 = 0; r1 = 0;
        for (int k = 0; k < 60 && (r0 + r1) < 6; k++) begin
            tick();
            if (bus1.gnt != 2'b00) begin
                exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
                chk("fair_gnt_order", bus1.gnt, exp_g);
                g++;
                if (g == 6) bus1.req = 2'b00;
            end
            r0 += int'(bus1.rsp_valid[0]);
            r1 += int'(bus1.rsp_valid[1]);
        end
        chk("fair_rsp_r0", r0, 3);
        chk("fair_rsp_r1", r1, 3);

        // Randomised traffic: withdrawals, queued follow-on requests, operand churn.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_gnt[i]) begin
                    bus1.req[i] = 1'($urandom_range(0, 1));
                    set_ops(i, 4'($urandom), 4'($urandom), 2'($urandom));
                end else if (bus1.req[i]) begin
                    if ($urandom_range(0, 7) == 0) bus1.req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus1.req[i] = 1'b1;
                    set_ops(i, 4'($urandom), 4'($urandom), 2'($urandom));
                end
            end
            tick();
        end
        bus1.req = 2'b00;
        repeat (6) tick();
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        chk("opcount_lat1", opc1, (((m_cnt[1] % 256) << 8) | (m_cnt[0] % 256)));
`endif

        // Back-to-back single requester on the ALU_LAT=0 and ALU_LAT=7 instances.
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        n_ops0 = 257;
`else
        n_ops0 = 6;
`endif
        bus0.req = 2'b01; bus0.op_a = 8'h03; bus0.op_b = 8'h05; bus0.op_func = 4'h0;
        bus7.req = 2'b01; bus7.op_a = 8'h03; bus7.op_b = 8'h05; bus7.op_func = 4'h0;
        n0 = 0; n7 = 0; last0 = 0; last7 = 0;
        for (int c = 0; c < 2 * n_ops0 + 80 && (n0 < n_ops0 || n7 < 4); c++) begin
            @(posedge clk); #1;
            if (bus0.gnt == 2'b01) begin
                if (n0 > 0) chk("spacing_lat0", c - last0, 2);
                last0 = c; n0++;
                if (n0 == n_ops0) bus0.req = 2'b00;
            end
            if (bus7.gnt == 2'b01) begin
                if (n7 > 0) chk("spacing_lat7", c - last7, 9);
                last7 = c; n7++;
                if (n7 == 4) bus7.req = 2'b00;
            end
            if (bus0.rsp_valid == 2'b01) chk("rsp_lat0", {c - last0, 24'(bus0.rsp_data)}, {32'd1 << 24 | 32'h08});
            if (bus7.rsp_valid == 2'b01) chk("rsp_lat7", {c - last7, 24'(bus7.rsp_data)}, {32'd8 << 24 | 32'h08});
        end
        chk("lat0_grants_done", n0, n_ops0);
        chk("lat7_grants_done", n7, 4);
        repeat (12) @(posedge clk);
        #1;
        chk("lat0_idle_after", bus0.busy, 0);
        chk("lat7_idle_after", bus7.busy, 0);
`ifdef ALU_SHARE_SCHED_OPCNT_EN
        chk("opcount_lat0_wrap", opc0, 16'h0001);
        chk("opcount_lat7", opc7, 16'h0004);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
